hilo_mult_unit: RTL and testbench
=================================

// Module: hilo_mult_unit
// PURPOSE
// - Consumes the EX-stage control word (enhilo_EX, alu_op, regsel_EX, regwrite_EX).
// - Runs an iterative mult/multu into architectural HI/LO registers.
// - Resolves the mfhi/mflo/ALU writeback select and registers the EX->WB writeback pair.
// - Stalls the front end while a multiply is in flight and a new mult or mfhi/mflo arrives.
// PARAMETERS
// - WIDTH          32  operand width; product is 2*WIDTH (HI = upper, LO = lower)
// - BITS_PER_CYCLE 1   multiplier bits retired per cycle; one of 1,2,4; must divide WIDTH
// PORTS
// - clk            in   1      single clock, rising edge
// - rst            in   1      synchronous, active-high reset
// - enhilo_EX      in   1      start request (mult/multu in EX)
// - alu_op         in   4      4'b0110 = signed mult, 4'b0111 = unsigned multu; else don't-care
// - regsel_EX      in   2      0 = ALU result, 1 = mfhi, 2 = mflo, 3 = treated as 0
// - regwrite_EX    in   1      EX instruction writes a GPR
// - rs_data_EX     in   WIDTH  multiplicand
// - rt_data_EX     in   WIDTH  multiplier
// - alu_result_EX  in   WIDTH  ALU result for regsel 0
// - stall_EX       out  1      combinational; upstream must hold the EX instruction while high
// - busy           out  1      multiply in progress
// - hi, lo         out  WIDTH  architectural HI/LO
// - writedata_WB   out  WIDTH  registered writeback data
// - regwrite_WB    out  1      registered writeback enable
// BEHAVIOUR
// - Reset values: hi = 0, lo = 0, writedata_WB = 0, regwrite_WB = 0, busy = 0, state = IDLE.
// - Reset mid-multiply aborts the operation; no partial HI/LO update.
// - FSM states: IDLE and RUN. N = WIDTH/BITS_PER_CYCLE.
// - IDLE -> RUN on an edge with enhilo_EX = 1 and busy = 0:
//   - latch |rs| and |rt| as unsigned WIDTH-bit magnitudes (0x80000000 -> 0x80000000);
//   - latch neg = signed & (rs[MSB] ^ rt[MSB]); zero the 2*WIDTH accumulator; cnt = N.
//   - multu: magnitudes = raw operands, neg = 0.
// - RUN, each edge: add shifted multiplicand per BITS_PER_CYCLE multiplier bits; cnt -= 1.
// - RUN, edge with cnt == 1: {hi,lo} <= neg ? -acc : acc; state -> IDLE.
// - busy == (state == RUN): high for exactly N cycles after the start edge.
// - New HI/LO values are visible in the cycle after the Nth RUN edge.
// - stall_EX = busy & (enhilo_EX | regsel_EX == 1 | regsel_EX == 2).
// - A start while busy is not accepted; the held instruction restarts once busy falls.
// - Operands of an in-flight multiply never change.
// - Writeback mux: sel = regsel_EX == 1 ? hi : regsel_EX == 2 ? lo : alu_result_EX.
//   - mfhi/mflo read the current hi/lo registers (no bypass; the stall covers the hazard).
// - WB register, every edge:
//   - regwrite_WB <= regwrite_EX & ~stall_EX & ~enhilo_EX
//     (mult/multu never write a GPR; a stalled instruction becomes a bubble);
//   - writedata_WB <= sel.
// - Arithmetic: 2*WIDTH accumulator; two's-complement negate at completion. 0 * anything = 0.
// - If enhilo_EX and the final RUN edge coincide: not accepted that cycle (busy still 1);
//   accepted on the next edge.
// CONFIGURATION
// - HILO_FAST_MULT_EN defined:
//   - RUN state and counter removed; {hi,lo} <= signed/unsigned product at the start edge;
//   - busy tied 0; stall_EX tied 0; BITS_PER_CYCLE ignored.
// - HILO_FAST_MULT_EN undefined: iterative FSM as above.
// TESTING
// - multu 0xFFFFFFFF * 0xFFFFFFFF -> busy 32 cycles, then hi = 0xFFFFFFFE, lo = 0x00000001.
// - mult signed -3 (0xFFFFFFFD) * 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1; regwrite_WB stays 0.
// - mult signed 0x80000000 * 0x80000000 -> hi = 0x40000000, lo = 0x00000000.
// - mult 7 * 6, then mfhi held from the next cycle:
//   - stall_EX = 1 until busy falls, regwrite_WB = 0 throughout;
//   - then writedata_WB = 0x00000000 with regwrite_WB = 1;
//   - mflo afterwards -> writedata_WB = 0x0000002A.
// - Second mult issued 5 cycles into the first:
//   - stall_EX = 1; first result unaffected; second starts the cycle after busy falls.
// - rst pulsed at RUN cycle 10 -> next cycle busy = 0, hi = lo = 0, regwrite_WB = 0.
// - With HILO_FAST_MULT_EN:
//   - 3 * 4 -> lo = 12 one edge after start; busy never 1;
//   - mfhi on the following cycle -> writedata_WB = 0.

Source files
------------

// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit: EX-stage HI/LO multiply unit with mfhi/mflo/ALU writeback
// selection and the registered EX->WB writeback pair.
// Default build runs mult/multu as a shift-and-add over WIDTH/BITS_PER_CYCLE
// cycles, stalling mult/mfhi/mflo that arrive while a multiply is in flight.
// Define HILO_FAST_MULT_EN to replace the iterative engine with a
// single-edge product (no busy, no stall, BITS_PER_CYCLE ignored).
module hilo_mult_unit #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enhilo_EX,
   input  logic [3:0]       alu_op,
   input  logic [1:0]       regsel_EX,
   input  logic             regwrite_EX,
   input  logic [WIDTH-1:0] rs_data_EX,
   input  logic [WIDTH-1:0] rt_data_EX,
   input  logic [WIDTH-1:0] alu_result_EX,
   output logic             stall_EX,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] writedata_WB,
   output logic             regwrite_WB
);

   localparam logic [3:0] OP_MULT = 4'b0110;

   logic             is_signed;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] writedata_wb_q, writedata_wb_d;
   logic             regwrite_wb_q, regwrite_wb_d;

   assign is_signed = (alu_op == OP_MULT);

`ifdef HILO_FAST_MULT_EN

   logic [2*WIDTH-1:0] rs_ext, rt_ext, product;

   // Single-edge product: extend operands to full width and multiply directly
   always_comb begin
      rs_ext  = {{WIDTH{is_signed & rs_data_EX[WIDTH-1]}}, rs_data_EX};
      rt_ext  = {{WIDTH{is_signed & rt_data_EX[WIDTH-1]}}, rt_data_EX};
      product = rs_ext * rt_ext;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (enhilo_EX) begin
         {hi_d, lo_d} = product;
      end
   end

   assign busy     = 1'b0;
   assign stall_EX = 1'b0;

`else

   localparam int N     = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(N + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
   logic [2*WIDTH-1:0] partial, acc_sum, result;
   logic [WIDTH-1:0]   mplier_q, mplier_d, rs_mag, rt_mag;
   logic               neg_q, neg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Operand magnitudes for the unsigned engine; the most negative value maps onto itself
   always_comb begin
      rs_mag = (is_signed && rs_data_EX[WIDTH-1]) ? -rs_data_EX : rs_data_EX;
      rt_mag = (is_signed && rt_data_EX[WIDTH-1]) ? -rt_data_EX : rt_data_EX;
   end

   // Retire BITS_PER_CYCLE multiplier bits per cycle and form the signed final result
   always_comb begin
      partial = '0;
      for (int b = 0; b < BITS_PER_CYCLE; b++) begin
         if (mplier_q[b]) begin
            partial = partial + (mcand_q << b);
         end
      end
      acc_sum = acc_q + partial;
      result  = neg_q ? -acc_sum : acc_sum;
   end

   // FSM next-state: latch operands on start, iterate in RUN, commit HI/LO on the last step
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         IDLE: begin
            if (enhilo_EX) begin
               mcand_d  = {{WIDTH{1'b0}}, rs_mag};
               mplier_d = rt_mag;
               acc_d    = '0;
               neg_d    = is_signed & (rs_data_EX[WIDTH-1] ^ rt_data_EX[WIDTH-1]);
               cnt_d    = CNT_W'(N);
               state_d  = RUN;
            end
         end
         RUN: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               {hi_d, lo_d} = result;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Multiply engine registers; reset aborts any multiply in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy     = (state_q == RUN);
   assign stall_EX = busy & (enhilo_EX | (regsel_EX == 2'd1) | (regsel_EX == 2'd2));

`endif

   // Writeback select and enable; mult/multu and stalled instructions never write a GPR
   always_comb begin
      case (regsel_EX)
         2'd1:    writedata_wb_d = hi_q;
         2'd2:    writedata_wb_d = lo_q;
         default: writedata_wb_d = alu_result_EX;
      endcase
      regwrite_wb_d = regwrite_EX & ~stall_EX & ~enhilo_EX;
   end

   // Architectural HI/LO and the EX->WB pipeline register
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q           <= '0;
         lo_q           <= '0;
         writedata_wb_q <= '0;
         regwrite_wb_q  <= 1'b0;
      end else begin
         hi_q           <= hi_d;
         lo_q           <= lo_d;
         writedata_wb_q <= writedata_wb_d;
         regwrite_wb_q  <= regwrite_wb_d;
      end
   end

   assign hi           = hi_q;
   assign lo           = lo_q;
   assign writedata_WB = writedata_wb_q;
   assign regwrite_WB  = regwrite_wb_q;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// tb_hilo_mult_unit: self-checking bench for hilo_mult_unit (iterative build).
// Expected products come from plain 64-bit arithmetic; latency and stall
// expectations come from the documented cycle behaviour.
module tb_hilo_mult_unit;

   localparam int WIDTH = 32;
   localparam int BPC   = 1;
   localparam int N     = WIDTH / BPC;
   localparam logic [3:0] OP_MULT  = 4'b0110;
   localparam logic [3:0] OP_MULTU = 4'b0111;

   logic        clk = 1'b0;
   logic        rst;
   logic        enhiloEx;
   logic [3:0]  aluOp;
   logic [1:0]  regselEx;
   logic        regwriteEx;
   logic [31:0] rsData, rtData, aluResult;
   logic        stallEx, busy, regwriteWb;
   logic [31:0] hi, lo, writedataWb;

   int          checkCount = 0;
   int          passCount  = 0;
   logic [31:0] refHi = '0;
   logic [31:0] refLo = '0;

   hilo_mult_unit #(.WIDTH(WIDTH), .BITS_PER_CYCLE(BPC)) dut (
      .clk          (clk),
      .rst          (rst),
      .enhilo_EX    (enhiloEx),
      .alu_op       (aluOp),
      .regsel_EX    (regselEx),
      .regwrite_EX  (regwriteEx),
      .rs_data_EX   (rsData),
      .rt_data_EX   (rtData),
      .alu_result_EX(aluResult),
      .stall_EX     (stallEx),
      .busy         (busy),
      .hi           (hi),
      .lo           (lo),
      .writedata_WB (writedataWb),
      .regwrite_WB  (regwriteWb)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Full 64-bit product of two 32-bit operands, signed or unsigned
   function automatic logic [63:0] refProduct(input bit isSigned, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb;
      if (isSigned) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
         return sa * sb;
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic en, input logic [3:0] op, input logic [1:0] sel,
                                input logic wr, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] alu);
      enhiloEx   = en;
      aluOp      = op;
      regselEx   = sel;
      regwriteEx = wr;
      rsData     = a;
      rtData     = b;
      aluResult  = alu;
      #1;
   endtask

   // Issue one mult/multu with regwrite_EX high, scramble operands after the start
   // edge, then wait for completion and compare busy length and HI/LO with the model
   task automatic runMult(input string tag, input bit isSigned, input logic [31:0] a,
                          input logic [31:0] b);
      logic [63:0] expProd;
      int          cycles;
      expProd = refProduct(isSigned, a, b);
      applyStimulus(1'b1, isSigned ? OP_MULT : OP_MULTU, 2'd0, 1'b1, a, b, $urandom);
      tick();
      applyStimulus(1'b0, 4'b0, 2'd0, 1'b0, $urandom, $urandom, $urandom);
      checkOutput({tag, " busy after start"}, busy, 1);
      checkOutput({tag, " regwrite_WB bubble"}, regwriteWb, 0);
      cycles = 0;
      while (busy === 1'b1 && cycles < 4 * N) begin
         tick();
         #1;
         cycles++;
      end
      checkOutput({tag, " busy cycles"}, cycles, N);
      checkOutput({tag, " hi"}, hi, expProd[63:32]);
      checkOutput({tag, " lo"}, lo, expProd[31:0]);
      refHi = expProd[63:32];
      refLo = expProd[31:0];
   endtask

   initial begin
      int          cycles;
      logic [1:0]  sel;
      logic        wr;
      logic [31:0] alu, opA, opB;
      logic [63:0] expProd;
      bit          sgn;

      rst = 1'b1;
      applyStimulus(1'b0, 4'b0, 2'd0, 1'b0, '0, '0, '0);
      tick();
      tick();
      checkOutput("reset busy", busy, 0);
      checkOutput("reset hi", hi, 0);
      checkOutput("reset lo", lo, 0);
      checkOutput("reset writedata_WB", writedataWb, 0);
      checkOutput("reset regwrite_WB", regwriteWb, 0);
      checkOutput("reset stall_EX", stallEx, 0);
      rst = 1'b0;

      runMult("multu max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checkOutput("multu max hi const", hi, 32'hFFFF_FFFE);
      checkOutput("multu max lo const", lo, 32'h0000_0001);

      runMult("mult -3*5", 1'b1, 32'hFFFF_FFFD, 32'd5);
      checkOutput("mult -3*5 hi const", hi, 32'hFFFF_FFFF);
      checkOutput("mult -3*5 lo const", lo, 32'hFFFF_FFF1);

      runMult("mult minneg sq", 1'b1, 32'h8000_0000, 32'h8000_0000);
      checkOutput("mult minneg hi const", hi, 32'h4000_0000);
      checkOutput("mult minneg lo const", lo, 32'h0000_0000);

      // mult 7*6 followed by a held mfhi, then mflo
      applyStimulus(1'b1, OP_MULT, 2'd0, 1'b0, 32'd7, 32'd6, '0);
      tick();
      applyStimulus(1'b0, 4'b0, 2'd1, 1'b1, '0, '0, 32'h1111_1111);
      cycles = 0;
      while (busy === 1'b1 && cycles < 4 * N) begin
         checkOutput("mfhi held stall_EX", stallEx, 1);
         checkOutput("mfhi held regwrite_WB", regwriteWb, 0);
         tick();
         #1;
         cycles++;
      end
      checkOutput("mfhi held cycles", cycles, N);
      checkOutput("mfhi released stall_EX", stallEx, 0);
      checkOutput("mfhi released regwrite_WB", regwriteWb, 0);
      tick();
      checkOutput("mfhi writedata_WB", writedataWb, 32'h0000_0000);
      checkOutput("mfhi regwrite_WB", regwriteWb, 1);
      applyStimulus(1'b0, 4'b0, 2'd2, 1'b1, '0, '0, 32'h1111_1111);
      tick();
      checkOutput("mflo writedata_WB", writedataWb, 32'h0000_002A);
      checkOutput("mflo regwrite_WB", regwriteWb, 1);
      refHi = 32'h0;
      refLo = 32'h2A;

      // Second mult arrives 5 cycles into the first and is held until busy falls
      opA = $urandom;
      opB = $urandom;
      expProd = refProduct(1'b1, 32'd100, 32'hFFFF_FFF9);
      applyStimulus(1'b1, OP_MULT, 2'd0, 1'b0, 32'd100, 32'hFFFF_FFF9, '0);
      tick();
      applyStimulus(1'b0, 4'b0, 2'd0, 1'b0, '0, '0, '0);
      for (int k = 0; k < 5; k++) tick();
      applyStimulus(1'b1, OP_MULTU, 2'd0, 1'b1, opA, opB, '0);
      cycles = 0;
      while (busy === 1'b1 && cycles < 4 * N) begin
         checkOutput("second mult stall_EX", stallEx, 1);
         tick();
         #1;
         cycles++;
      end
      checkOutput("second mult held cycles", cycles, N - 5);
      checkOutput("first result hi", hi, expProd[63:32]);
      checkOutput("first result lo", lo, expProd[31:0]);
      checkOutput("second mult no stall", stallEx, 0);
      checkOutput("second mult bubble", regwriteWb, 0);
      runMult("second mult", 1'b0, opA, opB);

      // Randomized multiplies against the arithmetic model
      for (int i = 0; i < 6; i++) begin
         sgn = 1'($urandom_range(0, 1));
         opA = $urandom;
         opB = (i == 0) ? 32'd0 : $urandom;
         runMult("random mult", sgn, opA, opB);
      end

      // Randomized writeback mux while idle
      for (int i = 0; i < 8; i++) begin
         sel = 2'($urandom_range(0, 3));
         wr  = 1'($urandom_range(0, 1));
         alu = $urandom;
         applyStimulus(1'b0, 4'b0, sel, wr, $urandom, $urandom, alu);
         tick();
         checkOutput("wb mux data", writedataWb,
                     (sel == 2'd1) ? refHi : (sel == 2'd2) ? refLo : alu);
         checkOutput("wb mux regwrite", regwriteWb, wr);
      end

      // Reset pulsed at RUN cycle 10 aborts the multiply with no partial HI/LO update
      applyStimulus(1'b1, OP_MULTU, 2'd0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, '0);
      tick();
      applyStimulus(1'b0, 4'b0, 2'd0, 1'b1, '0, '0, 32'hDEAD_BEEF);
      for (int k = 0; k < 9; k++) tick();
      rst = 1'b1;
      tick();
      checkOutput("mid reset busy", busy, 0);
      checkOutput("mid reset hi", hi, 0);
      checkOutput("mid reset lo", lo, 0);
      checkOutput("mid reset regwrite_WB", regwriteWb, 0);
      rst = 1'b0;
      applyStimulus(1'b0, 4'b0, 2'd0, 1'b0, '0, '0, '0);
      for (int k = 0; k < N + 2; k++) tick();
      checkOutput("after abort busy", busy, 0);
      checkOutput("after abort hi", hi, 0);
      checkOutput("after abort lo", lo, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
